// File: rtl/vend_panel_arbiter_if.sv
// Panel-side and machine-side signal bundle for vend_panel_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface vend_panel_arbiter_if #(
  parameter int NUM_PANELS     = 4,
  parameter int PRODUCT_WIDTH  = 2,
  parameter int CURRENCY_WIDTH = 3
);
  logic [NUM_PANELS-1:0]                i_req;
  logic [NUM_PANELS*PRODUCT_WIDTH-1:0]  i_product_code;
  logic [NUM_PANELS*CURRENCY_WIDTH-1:0] i_currency_code;
  logic [NUM_PANELS-1:0]                i_currency_strobe;
  logic [NUM_PANELS-1:0]                o_grant;
  logic [NUM_PANELS-1:0]                o_panel_ready;
  logic [NUM_PANELS-1:0]                o_give_strobe;
  logic [NUM_PANELS-1:0]                o_change_strobe;
  logic [NUM_PANELS-1:0]                o_no_change;
  logic [CURRENCY_WIDTH-1:0]            o_change;
  logic                                 o_err;
  logic [PRODUCT_WIDTH-1:0]             o_vm_product_code;
  logic                                 o_vm_product_strobe;
  logic [CURRENCY_WIDTH-1:0]            o_vm_currency_code;
  logic                                 o_vm_currency_strobe;
  logic                                 i_vm_busy;
  logic                                 i_vm_ready_to_receive;
  logic                                 i_vm_give_strobe;
  logic                                 i_vm_change_strobe;
  logic                                 i_vm_no_change;
  logic [CURRENCY_WIDTH-1:0]            i_vm_change;

  modport slave (
    input  i_req, i_product_code, i_currency_code, i_currency_strobe,
    input  i_vm_busy, i_vm_ready_to_receive, i_vm_give_strobe,
    input  i_vm_change_strobe, i_vm_no_change, i_vm_change,
    output o_grant, o_panel_ready, o_give_strobe, o_change_strobe, o_no_change,
    output o_change, o_err, o_vm_product_code, o_vm_product_strobe,
    output o_vm_currency_code, o_vm_currency_strobe
  );

  modport master (
    output i_req, i_product_code, i_currency_code, i_currency_strobe,
    output i_vm_busy, i_vm_ready_to_receive, i_vm_give_strobe,
    output i_vm_change_strobe, i_vm_no_change, i_vm_change,
    input  o_grant, o_panel_ready, o_give_strobe, o_change_strobe, o_no_change,
    input  o_change, o_err, o_vm_product_code, o_vm_product_strobe,
    input  o_vm_currency_code, o_vm_currency_strobe
  );
endinterface

// File: rtl/vend_panel_arbiter.sv
// Shares one vending machine among NUM_PANELS panels: grant registered one cycle after an IDLE request,
// machine strobes routed combinationally to the owner. VEND_ARB_PRIORITY_EN selects fixed priority over round-robin.
module vend_panel_arbiter #(
  parameter int NUM_PANELS     = 4,
  parameter int PRODUCT_WIDTH  = 2,
  parameter int CURRENCY_WIDTH = 3,
  parameter int BUSY_WAIT      = 4
) (
  input logic                 clk,
  input logic                 i_rst_n,
  vend_panel_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;
  localparam int CNT_W = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, SERVE, RELEASE} state_t;

  state_t                    state_q, state_d;
  logic [NUM_PANELS-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [PRODUCT_WIDTH-1:0]  prod_q, prod_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      win_vld;
  logic [IDX_W-1:0]          win_idx;
  logic                      serve;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
`ifdef VEND_ARB_PRIORITY_EN
    for (int i = NUM_PANELS - 1; i >= 0; i--) begin
      if (bus.i_req[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
`else
    // Scan from the farthest offset down so the requester nearest the pointer is assigned last.
    for (int i = NUM_PANELS - 1; i >= 0; i--) begin
      if (bus.i_req[(int'(ptr_q) + i) % NUM_PANELS]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(ptr_q) + i) % NUM_PANELS);
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = NUM_PANELS'(1) << win_idx;
          idx_d   = win_idx;
          prod_d  = bus.i_product_code[win_idx*PRODUCT_WIDTH +: PRODUCT_WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.i_vm_busy) begin
          state_d = SERVE;
        end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
          // Machine never acknowledged: abandon the session, pointer stays put.
          err_d   = 1'b1;
          grant_d = '0;
          prod_d  = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SERVE: begin
        if (!bus.i_vm_busy) state_d = RELEASE;
      end
      RELEASE: begin
        grant_d = '0;
        prod_d  = '0;
        ptr_d   = (idx_q == IDX_W'(NUM_PANELS - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign serve = (state_q == SERVE);

  assign bus.o_grant             = grant_q;
  assign bus.o_panel_ready       = grant_q & {NUM_PANELS{bus.i_vm_ready_to_receive}};
  assign bus.o_give_strobe       = grant_q & {NUM_PANELS{bus.i_vm_give_strobe}};
  assign bus.o_change_strobe     = grant_q & {NUM_PANELS{bus.i_vm_change_strobe}};
  assign bus.o_no_change         = grant_q & {NUM_PANELS{bus.i_vm_no_change}};
  assign bus.o_change            = (|grant_q) ? bus.i_vm_change : '0;
  assign bus.o_err               = err_q;
  assign bus.o_vm_product_code   = prod_q;
  assign bus.o_vm_product_strobe = (state_q == ISSUE);

  // While busy and not accepting coins the machine is paying out; keep strobing so change flows.
  assign bus.o_vm_currency_code = (serve && bus.i_vm_ready_to_receive)
                                  ? bus.i_currency_code[idx_q*CURRENCY_WIDTH +: CURRENCY_WIDTH] : '0;
  assign bus.o_vm_currency_strobe = serve &&
                                    ((bus.i_vm_ready_to_receive && bus.i_currency_strobe[idx_q]) ||
                                     (bus.i_vm_busy && !bus.i_vm_ready_to_receive));
endmodule
